// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop bank among several requesters.
// Tracks a shadow of the bank and flags any readback mismatch.
module tff_toggle_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*IDXW-1:0] req_idx,
   input  logic                 clr,
   output logic [NREQ-1:0]      ack,
   output logic [WIDTH-1:0]     t_out,
   output logic                 bank_clr,
   input  logic [WIDTH-1:0]     q_in,
   output logic [WIDTH-1:0]     q_shadow,
   output logic                 busy,
   output logic                 err,
   output logic [IDXW-1:0]      err_idx
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_CHECK  = 3'd2;
   localparam logic [2:0] S_CLEAR  = 3'd3;
   localparam logic [2:0] S_CLRCHK = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [GW-1:0]    rr_q, rr_d;
   logic [GW-1:0]    gnt_q, gnt_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic             bclr_q, bclr_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [IDXW-1:0]  eidx_q, eidx_d;

   logic [NREQ-1:0]  arb_req;
   logic [GW-1:0]    arb_ptr;
   logic [GW-1:0]    gnt_nxt;
   logic [GW-1:0]    pick;
   logic             found;
   logic [IDXW-1:0]  pick_idx;
   logic [WIDTH-1:0] pick_t;
   logic             bad_idx;

   // In CHECK the acked requester may still hold req, so it is masked out.
   always_comb begin
      gnt_nxt = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
      arb_req = req;
      arb_ptr = rr_q;
      if (state_q == S_CHECK) begin
         arb_req = req & ~(NREQ'(1) << gnt_q);
         arb_ptr = gnt_nxt;
      end
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && arb_req[(int'(arb_ptr) + k) % NREQ]) begin
            found = 1'b1;
            pick  = GW'((int'(arb_ptr) + k) % NREQ);
         end
      end
      pick_idx = req_idx[int'(pick)*IDXW +: IDXW];
      pick_t   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pick_t[i] = (int'(pick_idx) == i);
      end
      bad_idx = (int'(idx_q) >= WIDTH);
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ack_d   = '0;
      t_d     = '0;
      bclr_d  = 1'b0;
      sh_d    = sh_q;
      err_d   = err_q;
      eidx_d  = eidx_q;
      case (state_q)
         S_IDLE: begin
            if (clr) begin
               state_d = S_CLEAR;
            end else if (found) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            sh_d         = sh_q ^ t_q;
            ack_d[gnt_q] = 1'b1;
            state_d      = S_CHECK;
         end
         S_CHECK: begin
            if ((q_in != sh_q || bad_idx) && !err_q) begin
               err_d  = 1'b1;
               eidx_d = idx_q;
            end
            rr_d = gnt_nxt;
            if (clr) begin
               state_d = S_CLEAR;
            end else if (found) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            state_d = S_CLRCHK;
         end
         S_CLRCHK: begin
            if (q_in != '0) begin
               err_d  = 1'b1;
               eidx_d = '0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Registered outputs are loaded on entry to the state that shows them.
      if (state_d == S_ISSUE) begin
         gnt_d = pick;
         idx_d = pick_idx;
         t_d   = pick_t;
      end
      if (state_d == S_CLEAR) begin
         bclr_d = 1'b1;
         sh_d   = '0;
         err_d  = 1'b0;
         eidx_d = '0;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         ack_q   <= '0;
         t_q     <= '0;
         bclr_q  <= 1'b0;
         sh_q    <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         eidx_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         t_q     <= t_d;
         bclr_q  <= bclr_d;
         sh_q    <= sh_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         eidx_q  <= eidx_d;
      end
   end

   assign ack      = ack_q;
   assign t_out    = t_q;
   assign bank_clr = bclr_q;
   assign q_shadow = sh_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign err_idx  = eidx_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter driving a behavioural T-FF bank
// with an optional stuck-at-0 bit.
module tb_tff_toggle_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;
   localparam int IDXW  = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*IDXW-1:0] req_idx = '0;
   logic                 clr = 1'b0;
   logic [NREQ-1:0]      ack;
   logic [WIDTH-1:0]     t_out;
   logic                 bank_clr;
   logic [WIDTH-1:0]     q_in;
   logic [WIDTH-1:0]     q_shadow;
   logic                 busy;
   logic                 err;
   logic [IDXW-1:0]      err_idx;

   logic [WIDTH-1:0]     bank = '0;
   logic [WIDTH-1:0]     stuck = '0;

   typedef struct {
      logic [NREQ-1:0]  ack;
      logic [WIDTH-1:0] t;
      logic [WIDTH-1:0] sh;
      int               gap;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   logic [WIDTH-1:0] prev_t = '0;

   tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_idx(req_idx), .clr(clr),
      .ack(ack), .t_out(t_out), .bank_clr(bank_clr), .q_in(q_in),
      .q_shadow(q_shadow), .busy(busy), .err(err), .err_idx(err_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || bank_clr) bank <= '0;
      else bank <= bank ^ t_out;
   end

   assign q_in = bank & ~stuck;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every ack cycle is matched against the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (|ack) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ack actual=%0h required=0", ack);
            end else begin
               e = sb.pop_front();
               chk("ack", 32'(ack), 32'(e.ack));
               chk("t_out", 32'(prev_t), 32'(e.t));
               chk("q_shadow", 32'(q_shadow), 32'(e.sh));
               if (e.gap != 0) chk("ack_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
         end
         prev_t = t_out;
      end
   end

   // Requesters drop their request once acknowledged.
   initial begin
      forever begin
         @(negedge clk);
         req = req & ~ack;
      end
   end

   task automatic push(input logic [NREQ-1:0] a, input logic [WIDTH-1:0] t,
                       input logic [WIDTH-1:0] sh, input int gap);
      exp_t e;
      e.ack = a; e.t = t; e.sh = sh; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic set_idx(input int r, input int v);
      req_idx[r*IDXW +: IDXW] = IDXW'(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      clr   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 40) begin
         tick();
         n++;
      end
      chk({name, "_drain"}, 32'(n < 40), 32'd1);
   endtask

   initial begin
      do_reset();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_t_out", 32'(t_out), 32'd0);
      chk("rst_bank_clr", 32'(bank_clr), 32'd0);
      chk("rst_q_shadow", 32'(q_shadow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_idx", 32'(err_idx), 32'd0);

      set_idx(0, 3);
      push(4'b0001, 6'h08, 6'h08, 0);
      req = 4'b0001;
      tick();
      chk("single_t_out", 32'(t_out), 32'h08);
      chk("single_busy", 32'(busy), 32'd1);
      tick();
      chk("single_ack", 32'(ack), 32'b0001);
      drain("single");
      chk("single_err", 32'(err), 32'd0);

      do_reset();
      for (int r = 0; r < NREQ; r++) set_idx(r, r);
      push(4'b0001, 6'h01, 6'h01, 0);
      push(4'b0010, 6'h02, 6'h03, 2);
      push(4'b0100, 6'h04, 6'h07, 2);
      push(4'b1000, 6'h08, 6'h0F, 2);
      req = 4'b1111;
      drain("rr4");
      chk("rr4_shadow", 32'(q_shadow), 32'h0F);
      set_idx(0, 4);
      set_idx(2, 5);
      push(4'b0001, 6'h10, 6'h1F, 0);
      push(4'b0100, 6'h20, 6'h3F, 2);
      req = 4'b0101;
      drain("rr2");
      chk("rr2_err", 32'(err), 32'd0);

      do_reset();
      stuck = 6'h20;
      set_idx(1, 5);
      push(4'b0010, 6'h20, 6'h20, 0);
      req = 4'b0010;
      drain("stuck");
      chk("stuck_err", 32'(err), 32'd1);
      chk("stuck_err_idx", 32'(err_idx), 32'd5);
      set_idx(1, 1);
      push(4'b0010, 6'h02, 6'h22, 0);
      req = 4'b0010;
      drain("stuck2");
      chk("stuck2_err_idx", 32'(err_idx), 32'd5);
      stuck = '0;

      do_reset();
      set_idx(3, 7);
      push(4'b1000, 6'h00, 6'h00, 0);
      req = 4'b1000;
      drain("badidx");
      chk("badidx_err", 32'(err), 32'd1);
      chk("badidx_err_idx", 32'(err_idx), 32'd7);

      set_idx(0, 2);
      push(4'b0001, 6'h04, 6'h04, 0);
      req = 4'b0001;
      tick();
      clr = 1'b1;
      tick();
      tick();
      chk("clr_bank_clr", 32'(bank_clr), 32'd1);
      chk("clr_shadow", 32'(q_shadow), 32'd0);
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_err_idx", 32'(err_idx), 32'd0);
      clr = 1'b0;
      tick();
      chk("clrchk_bank_clr", 32'(bank_clr), 32'd0);
      chk("clrchk_q_in", 32'(q_in), 32'd0);
      chk("clrchk_busy", 32'(busy), 32'd1);
      tick();
      chk("clrdone_err", 32'(err), 32'd0);
      chk("clrdone_busy", 32'(busy), 32'd0);

      set_idx(2, 1);
      push(4'b0100, 6'h02, 6'h02, 0);
      req = 4'b0100;
      tick();
      chk("abort_t_out", 32'(t_out), 32'h02);
      rst_n = 1'b0;
      tick();
      chk("abort_ack", 32'(ack), 32'd0);
      chk("abort_t_zero", 32'(t_out), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_shadow", 32'(q_shadow), 32'd0);
      rst_n = 1'b1;
      drain("regrant");
      chk("regrant_err", 32'(err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tff_toggle_arbiter.md
# tff_toggle_arbiter

Round-robin controller that shares one bank of WIDTH edge-triggered T flip-flops among NREQ requesters. Each requester asks for one bit to be toggled. The arbiter grants one request at a time and drives a one-hot toggle strobe into the bank. It keeps a shadow copy of the expected bank state, checks the bank's q outputs after every toggle, and flags any mismatch. It sits between requester logic and the T-FF bank, and also sequences bank clears.

## Interface
- NREQ, 4, number of requesters
- WIDTH, 8, number of T flip-flops in the bank
- IDXW, 3, width of each bit-index field

- clk  in  1  system clock, rising-edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester toggle request, level, held until ack
- req_idx  in  NREQ*IDXW  bit index per requester; requester r uses bits [r*IDXW +: IDXW]
- clr  in  1  request to clear the bank, level
- ack  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- t_out  out  WIDTH  one-hot toggle strobe to the bank's T inputs
- bank_clr  out  1  one-cycle clear strobe to the bank
- q_in  in  WIDTH  bank q outputs
- q_shadow  out  WIDTH  expected bank state
- busy  out  1  high in every state except IDLE
- err  out  1  sticky mismatch / bad-index flag
- err_idx  out  IDXW  index of the first error since the last clear

## Operation
- FSM states: IDLE, ISSUE, CHECK, CLEAR, CLRCHK. All outputs are registered.
- IDLE
  - If clr=1, go to CLEAR. clr has priority over req.
  - Else if any req is set, grant the first set req at or after rr_ptr (wrapping at NREQ), latch grant and idx, and go to ISSUE.
  - Else stay in IDLE.
- ISSUE (one cycle)
  - If idx < WIDTH, t_out[idx]=1 and q_shadow[idx] inverts at the end of the cycle.
  - If idx >= WIDTH, t_out=0 and the shadow is unchanged. This is a bad-index error.
  - Go to CHECK.
- CHECK (one cycle)
  - ack[grant]=1.
  - If q_in != q_shadow, or the index was bad, and err=0: set err=1 and err_idx=idx.
  - rr_ptr = grant+1 mod NREQ.
  - Next state: CLEAR if clr=1; else ISSUE if another req is pending (arbitrated with the updated rr_ptr); else IDLE.
- CLEAR (one cycle)
  - bank_clr=1, q_shadow=0, err=0, err_idx=0.
  - Go to CLRCHK.
- CLRCHK (one cycle)
  - If q_in != 0, set err=1 and err_idx=0.
  - Go to IDLE. clr must be deasserted by this cycle, otherwise a second clear runs.
- The granted requester must hold req and req_idx stable until its ack. If req drops while a grant is in flight, the toggle still completes and ack still pulses.
- Requests that are pending but not granted may be withdrawn freely.
- err stays set until reset or CLEAR. Only the first error is recorded in err_idx.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, rr_ptr=0.
  - ack=0, t_out=0, bank_clr=0, q_shadow=0, busy=0, err=0, err_idx=0.
- Reset overrides every state, including mid-ISSUE and mid-CLEAR. No ack is issued for an aborted grant.
- Latency:
  - req sampled in IDLE at edge N.
  - t_out high during cycle N+1.
  - q_in checked and ack high during cycle N+2.
- The bank must settle q within one cycle of the t_out strobe.
- Back-to-back throughput is one toggle per 2 cycles: CHECK→ISSUE with no IDLE in between.
- clr asserted during ISSUE is deferred until after CHECK. The in-flight toggle always completes first.
- busy=1 from the cycle after the grant through the CHECK or CLRCHK cycle.

## Test plan
- Reset then single request: req=0001, idx0=3 → t_out=0x08 in cycle 2, ack=0001 in cycle 3, q_shadow=0x08, err=0.
- All four request at once with idx 0,1,2,3 and rr_ptr=0:
  - grants go 0,1,2,3, acks spaced 2 cycles apart, final q_shadow=0x0F.
  - Re-raise req[0] and req[2] → grant order 0 then 2.
- Fault injection: bank model holds q[5] stuck at 0, request idx=5 → in CHECK err=1, err_idx=5. A later good toggle of idx 1 leaves err_idx=5.
- Bad index: WIDTH=6, idx=7 → t_out=0, ack pulses, err=1, err_idx=7, q_shadow unchanged.
- clr raised during ISSUE of idx=2:
  - toggle completes and ack pulses, then bank_clr pulses one cycle.
  - q_shadow=0, err=0, and the bank reads 0 in CLRCHK.
- rst_n=0 during ISSUE → next cycle all outputs 0, state IDLE, no ack. A pending req is re-granted after rst_n=1.
